// File: rtl/decoder_stream_ctrl.sv
// Codeword FIFO feeding an external cw->binary core, MSB-first bit packer and message sequencer.
// Optional sticky error flags (err port) are built when DEC_ERR_EN is defined.
module decoder_stream_ctrl #(
  parameter int CW_W      = 10,
  parameter int DEPTH     = 32,
  parameter int MSG_WORDS = 10,
  parameter int OUT_W     = 8
) (
  input  logic                   clk,
  input  logic                   rst_b,
  input  logic                   start,
  input  logic [CW_W-1:0]        cw_in,
  input  logic                   wr_en,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level,
  output logic [CW_W-1:0]        core_word,
  output logic                   core_vld,
  input  logic                   core_rdy,
  input  logic                   core_bit,
  input  logic                   core_bit_vld,
  input  logic                   core_word_done,
  output logic [OUT_W-1:0]       msg_data,
  output logic                   msg_vld,
  output logic                   msg_done,
  output logic                   busy
`ifdef DEC_ERR_EN
  ,
  output logic [1:0]             err
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int BW = $clog2(OUT_W + 1);
  localparam int WW = $clog2(MSG_WORDS + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_FLUSH = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;

  logic [CW_W-1:0]   mem_r [DEPTH];
  logic [AW:0]       wptr_r;
  logic [AW:0]       rptr_r;
  logic [AW:0]       level_s;
  logic              full_s;
  logic              empty_s;
  logic              pop_s;
  logic              wr_acc_s;
  logic              wr_drop_s;

  logic [WW-1:0]     word_cnt_r;
  logic [BW-1:0]     bit_cnt_r;
  logic [OUT_W-1:0]  packer_r;
  logic [OUT_W-1:0]  msg_data_r;
  logic              msg_vld_r;
  logic              msg_done_r;

  logic [OUT_W-1:0]  packer_shift_s;
  logic [BW-1:0]     bit_inc_s;
  logic              word_full_s;
  logic              word_last_s;
  logic [OUT_W-1:0]  flush_word_s;
  logic              in_wait_s;

  // FIFO status decode from the pointer pair (extra MSB distinguishes full from empty)
  assign level_s   = wptr_r - rptr_r;
  assign full_s    = (level_s == (AW+1)'(DEPTH));
  assign empty_s   = (level_s == {(AW+1){1'b0}});
  assign in_wait_s = (state_r == S_WAIT);

  assign core_vld  = (state_r == S_FETCH) && !empty_s;
  assign pop_s     = core_vld && core_rdy;
  // A pop in the same cycle frees the slot, so a write against a full FIFO still lands.
  assign wr_acc_s  = wr_en && (!full_s || pop_s);
  assign wr_drop_s = wr_en && !wr_acc_s;

  assign full      = full_s;
  assign empty     = empty_s;
  assign level     = level_s;
  assign core_word = empty_s ? {CW_W{1'b0}} : mem_r[rptr_r[AW-1:0]];
  assign busy      = (state_r != S_IDLE);
  assign msg_data  = msg_data_r;
  assign msg_vld   = msg_vld_r;
  assign msg_done  = msg_done_r;

  // Packer arithmetic shared by the WAIT and FLUSH paths
  assign packer_shift_s = {packer_r[OUT_W-2:0], core_bit};
  assign bit_inc_s      = bit_cnt_r + BW'(1);
  assign word_full_s    = (bit_inc_s == BW'(OUT_W));
  assign word_last_s    = (word_cnt_r == WW'(MSG_WORDS - 1));
  assign flush_word_s   = packer_r << (BW'(OUT_W) - bit_cnt_r);

  // FIFO storage: contents are qualified by the pointers, so no reset is needed
  always_ff @(posedge clk) begin
    if (wr_acc_s) begin
      mem_r[wptr_r[AW-1:0]] <= cw_in;
    end
  end

  // FIFO pointers
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wptr_r <= {(AW+1){1'b0}};
      rptr_r <= {(AW+1){1'b0}};
    end else begin
      if (wr_acc_s) begin
        wptr_r <= wptr_r + (AW+1)'(1);
      end
      if (pop_s) begin
        rptr_r <= rptr_r + (AW+1)'(1);
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state decode
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          state_nxt_s = S_FETCH;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_FETCH: begin
        if (pop_s) begin
          state_nxt_s = S_WAIT;
        end else begin
          state_nxt_s = S_FETCH;
        end
      end
      S_WAIT: begin
        if (core_word_done && word_last_s) begin
          state_nxt_s = S_FLUSH;
        end else if (core_word_done) begin
          state_nxt_s = S_FETCH;
        end else begin
          state_nxt_s = S_WAIT;
        end
      end
      S_FLUSH: state_nxt_s = S_DONE;
      S_DONE:  state_nxt_s = S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Message datapath: counters, packer and registered strobes
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      word_cnt_r <= {WW{1'b0}};
      bit_cnt_r  <= {BW{1'b0}};
      packer_r   <= {OUT_W{1'b0}};
      msg_data_r <= {OUT_W{1'b0}};
      msg_vld_r  <= 1'b0;
      msg_done_r <= 1'b0;
    end else begin
      msg_vld_r  <= 1'b0;
      msg_done_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (start) begin
            word_cnt_r <= {WW{1'b0}};
            bit_cnt_r  <= {BW{1'b0}};
            packer_r   <= {OUT_W{1'b0}};
          end
        end
        S_WAIT: begin
          // The bit is taken before word_done advances the word count.
          if (core_bit_vld) begin
            packer_r <= packer_shift_s;
            if (word_full_s) begin
              msg_data_r <= packer_shift_s;
              msg_vld_r  <= 1'b1;
              bit_cnt_r  <= {BW{1'b0}};
            end else begin
              bit_cnt_r  <= bit_inc_s;
            end
          end
          if (core_word_done) begin
            word_cnt_r <= word_cnt_r + WW'(1);
          end
        end
        S_FLUSH: begin
          if (bit_cnt_r != {BW{1'b0}}) begin
            msg_data_r <= flush_word_s;
            msg_vld_r  <= 1'b1;
            bit_cnt_r  <= {BW{1'b0}};
          end
        end
        S_DONE: begin
          // Raised one cycle after any flush word so the last data always leads msg_done.
          msg_done_r <= 1'b1;
        end
        default: begin
          msg_done_r <= 1'b0;
        end
      endcase
    end
  end

`ifdef DEC_ERR_EN
  logic [1:0] err_r;
  logic       err_clr_s;
  logic [1:0] err_set_s;

  assign err_clr_s = start && (state_r == S_IDLE);
  assign err_set_s = {(core_bit_vld || core_word_done) && !in_wait_s, wr_drop_s};
  assign err       = err_r;

  // Sticky error flags, cleared by an accepted start
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      err_r <= 2'b00;
    end else begin
      err_r <= (err_clr_s ? 2'b00 : err_r) | err_set_s;
    end
  end
`endif

endmodule
